// File: rtl/vga_scanout_pkg.sv
// Shared definitions for the VGA scan-out block.
// Holds the default 640x480 timing, the prefetch FIFO entry type (colour plus
// start-of-frame tag), the control-state encoding, and a helper that maps a
// "sync asserted" flag onto the configured pin polarity.
package vga_scanout_pkg;

  localparam int PIX_W = 24;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] rgb;
  } pixel_t;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Pin level for a sync pulse: the active level when asserted, its inverse otherwise.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Pixel stream between the framebuffer reader (master) and the scan-out block (slave).
//   valid : master has a pixel on data/sof
//   data  : {R[23:16], G[15:8], B[7:0]}
//   sof   : pixel is the first of a frame (x=0, y=0)
//   ready : slave can accept; a transfer happens when valid && ready at a clock edge
interface vga_scanout_if;
  import vga_scanout_pkg::*;

  logic             valid;
  logic [PIX_W-1:0] data;
  logic             sof;
  logic             ready;

  modport master (output valid, output data, output sof, input ready);
  modport slave  (input valid, input data, input sof, output ready);
endinterface

// File: rtl/vga_scanout_fifo.sv
// vga_pixel_fifo: synchronous prefetch FIFO for tagged pixels.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and entry; ignored while full
//   pop, dout  : read request and current head; pop ignored while empty
//   full/empty : derived from a registered occupancy count, so a pop frees
//                its slot only from the following cycle
module vga_pixel_fifo
  import vga_scanout_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  pixel_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing generator with a prefetching pixel input.
// Ports:
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   pix (slave)       : valid/ready pixel stream with start-of-frame tag
//   underflow_clr     : clears the sticky underflow flag (a new underflow wins)
//   vga_hsync/vsync   : sync pulses at SYNC_POL active level
//   vga_blank         : 1 outside the active area
//   vga_red/green/blue: pixel colour, 0 when blanked or when no pixel is shown
//   frame_start       : one-cycle pulse with the first active pixel of a displayed frame
//   underflow         : sticky; FIFO ran dry or a start-of-frame arrived out of place
// All VGA outputs are registered, one cycle behind the raster counters.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_scanout_if.slave pix,
  input  logic         underflow_clr,
  output logic         vga_hsync,
  output logic         vga_vsync,
  output logic         vga_blank,
  output logic [7:0]   vga_red,
  output logic [7:0]   vga_green,
  output logic [7:0]   vga_blue,
  output logic         frame_start,
  output logic         underflow
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W   = $clog2(H_TOT);
  localparam int V_W   = $clog2(V_TOT);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOT - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOT - 1);

  logic [H_W-1:0]   h_cnt_r;
  logic [V_W-1:0]   v_cnt_r;
  state_t           state_r;
  logic [PIX_W-1:0] rgb_r;

  logic             h_last_s;
  logic             frame_last_s;
  logic             frame_first_s;
  logic             active_s;
  logic             hsync_on_s;
  logic             vsync_on_s;

  pixel_t           din_s;
  pixel_t           head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;

  state_t           state_nxt_s;
  logic [PIX_W-1:0] rgb_s;
  logic             fs_s;
  logic             set_uf_s;

  // ---------------- prefetch FIFO ----------------
  assign din_s     = '{sof: pix.sof, rgb: pix.data};
  assign push_s    = pix.valid && !full_s;
  assign pix.ready = !full_s;

  vga_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   (din_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Raster position decode from the current counter values.
  always_comb begin
    h_last_s      = (h_cnt_r == H_LAST);
    frame_last_s  = h_last_s && (v_cnt_r == V_LAST);
    frame_first_s = (h_cnt_r == {H_W{1'b0}}) && (v_cnt_r == {V_W{1'b0}});
    active_s      = (int'(h_cnt_r) < H_ACTIVE) && (int'(v_cnt_r) < V_ACTIVE);
    hsync_on_s    = (int'(h_cnt_r) >= H_ACTIVE + H_FP) &&
                    (int'(h_cnt_r) <  H_ACTIVE + H_FP + H_SYNC);
    vsync_on_s    = (int'(v_cnt_r) >= V_ACTIVE + V_FP) &&
                    (int'(v_cnt_r) <  V_ACTIVE + V_FP + V_SYNC);
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= {H_W{1'b0}};
      v_cnt_r <= {V_W{1'b0}};
    end else if (h_last_s) begin
      h_cnt_r <= {H_W{1'b0}};
      v_cnt_r <= (v_cnt_r == V_LAST) ? {V_W{1'b0}} : v_cnt_r + V_W'(1);
    end else begin
      h_cnt_r <= h_cnt_r + H_W'(1);
    end
  end

  // Control decisions for this cycle: what to pop, what to show, where to go next.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    rgb_s       = {PIX_W{1'b0}};
    fs_s        = 1'b0;
    set_uf_s    = 1'b0;
    case (state_r)
      RESYNC: begin
        // Throw away anything ahead of a start-of-frame; hold the sof pixel
        // until the raster is about to wrap so it lands exactly on (0,0).
        if (!empty_s && !head_s.sof) begin
          pop_s = 1'b1;
        end else if (!empty_s && frame_last_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = RESYNC;
        end
      end
      RUN: begin
        if (active_s) begin
          if (empty_s) begin
            set_uf_s    = 1'b1;
            state_nxt_s = DRAIN;
          end else if (head_s.sof && !frame_first_s) begin
            // Misaligned frame start: keep the sof pixel for the next resync.
            set_uf_s    = 1'b1;
            state_nxt_s = DRAIN;
          end else begin
            pop_s = 1'b1;
            rgb_s = head_s.rgb;
            fs_s  = frame_first_s;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (frame_last_s) begin
          state_nxt_s = RESYNC;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = RESYNC;
      end
    endcase
  end

  // Control state and all registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RESYNC;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      vga_blank   <= 1'b1;
      rgb_r       <= {PIX_W{1'b0}};
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      vga_hsync   <= sync_level(hsync_on_s, SYNC_POL);
      vga_vsync   <= sync_level(vsync_on_s, SYNC_POL);
      vga_blank   <= !active_s;
      rgb_r       <= rgb_s;
      frame_start <= fs_s;
      if (set_uf_s) begin
        underflow <= 1'b1;
      end else if (underflow_clr) begin
        underflow <= 1'b0;
      end else begin
        underflow <= underflow;
      end
    end
  end

  assign vga_red   = rgb_r[23:16];
  assign vga_green = rgb_r[15:8];
  assign vga_blue  = rgb_r[7:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout with a small raster (14x7 totals, 8x4 active)
// and a 4-entry FIFO. A frame-level reference model predicts every output cycle
// into a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PT = HT * VT;
  localparam int DEPTH = 4;

  localparam int M_RESYNC = 0, M_RUN = 1, M_DRAIN = 2;

  typedef struct {
    logic        sof;
    logic [23:0] rgb;
  } mpix_t;

  typedef struct {
    logic        hs, vs, bl;
    logic [23:0] rgb;
    logic        fs, uf, rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       underflow_clr = 1'b0;
  logic       vga_hsync, vga_vsync, vga_blank, frame_start, underflow;
  logic [7:0] vga_red, vga_green, vga_blue;

  vga_scanout_if pix_if();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix           (pix_if),
    .underflow_clr (underflow_clr),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_blank     (vga_blank),
    .vga_red       (vga_red),
    .vga_green     (vga_green),
    .vga_blue      (vga_blue),
    .frame_start   (frame_start),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    fs_seen = 0;
  bit    abort_send = 1'b0;

  mpix_t mq[$];
  exp_t  sb[$];
  int    mode = M_RESYNC;
  int    pos = 0;
  logic  uf_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one step per pixel clock, raster index pos = v*HT + h.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        sb.delete();
        mode = M_RESYNC;
        pos  = 0;
        uf_m = 1'b0;
      end else begin
        int    h, v;
        bit    act, last, acc, set;
        exp_t  e;
        mpix_t np;
        h    = pos % HT;
        v    = pos / HT;
        act  = (h < HA) && (v < VA);
        last = (pos == PT - 1);
        acc  = pix_if.valid && (mq.size() < DEPTH);
        set  = 1'b0;
        e.rgb = 24'h0;
        e.fs  = 1'b0;
        if (mode == M_RESYNC) begin
          if (mq.size() > 0 && !mq[0].sof) void'(mq.pop_front());
          else if (mq.size() > 0 && last) mode = M_RUN;
        end else if (mode == M_RUN) begin
          if (act) begin
            if (mq.size() == 0 || (mq[0].sof && pos != 0)) begin
              set  = 1'b1;
              mode = M_DRAIN;
            end else begin
              np    = mq.pop_front();
              e.rgb = np.rgb;
              e.fs  = (pos == 0);
            end
          end
        end else begin
          if (last) mode = M_RESYNC;
        end
        if (acc) begin
          np.sof = pix_if.sof;
          np.rgb = pix_if.data;
          mq.push_back(np);
        end
        uf_m  = set ? 1'b1 : (underflow_clr ? 1'b0 : uf_m);
        e.hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.bl  = !act;
        e.uf  = uf_m;
        e.rdy = (mq.size() < DEPTH);
        sb.push_back(e);
        pos = (pos + 1) % PT;
      end
    end
  end

  // Monitor: compares the pins with the oldest prediction on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        chk("rst_hsync", 32'(vga_hsync), 32'd1);
        chk("rst_vsync", 32'(vga_vsync), 32'd1);
        chk("rst_blank", 32'(vga_blank), 32'd1);
        chk("rst_rgb", {8'h0, vga_red, vga_green, vga_blue}, 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
      end else if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("hsync", 32'(vga_hsync), 32'(e.hs));
        chk("vsync", 32'(vga_vsync), 32'(e.vs));
        chk("blank", 32'(vga_blank), 32'(e.bl));
        chk("rgb", {8'h0, vga_red, vga_green, vga_blue}, {8'h0, e.rgb});
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("underflow", 32'(underflow), 32'(e.uf));
        chk("pix_ready", 32'(pix_if.ready), 32'(e.rdy));
        if (frame_start === 1'b1) fs_seen++;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [23:0] d, input logic s);
    int n;
    @(negedge clk);
    pix_if.valid = 1'b1;
    pix_if.data  = d;
    pix_if.sof   = s;
    n = 0;
    forever begin
      @(posedge clk);
      if (abort_send || pix_if.ready) break;
      n++;
      if (n > 1000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=stalled required=accepted t=%0t", $time);
        break;
      end
    end
  endtask

  task automatic send_seq(input int n, input logic [23:0] start, input bit sof_first, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (abort_send) break;
      send(rnd ? 24'($urandom) : start + 24'(i), sof_first && (i == 0));
    end
  endtask

  task automatic stop_stream();
    @(negedge clk);
    pix_if.valid = 1'b0;
    pix_if.sof   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    pix_if.valid = 1'b0;
    pix_if.data  = 24'h0;
    pix_if.sof   = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_blank", 32'(vga_blank), 32'd1);
    wait_cycles(3);
    release_reset();

    // Idle raster: syncs and blanking only.
    wait_cycles(2 * PT);
    chk("idle_uf", 32'(underflow), 32'd0);
    chk("idle_fs_count", 32'(fs_seen), 32'd0);

    // Counting frame then a random frame, then the stream stops.
    send_seq(32, 24'h000001, 1'b1, 1'b0);
    send_seq(32, 24'h0, 1'b1, 1'b1);
    stop_stream();
    wait_cycles(3 * PT);
    chk("stream_fs_count", 32'(fs_seen), 32'd2);
    chk("stream_end_uf", 32'(underflow), 32'd1);
    pulse_clr();
    chk("clr_uf", 32'(underflow), 32'd0);

    // Junk ahead of a frame.
    wait_cycles($urandom_range(0, 40));
    send_seq(3, 24'h0, 1'b0, 1'b1);
    send_seq(32, 24'h0, 1'b1, 1'b1);
    stop_stream();
    wait_cycles(3 * PT);
    chk("junk_fs_count", 32'(fs_seen), 32'd3);
    pulse_clr();
    chk("clr_uf2", 32'(underflow), 32'd0);

    // Upstream stall after 10 pixels, then recovery on a fresh frame.
    wait_cycles($urandom_range(0, 40));
    send_seq(10, 24'h000100, 1'b1, 1'b0);
    stop_stream();
    wait_cycles(3 * PT);
    chk("stall_uf", 32'(underflow), 32'd1);
    send_seq(22, 24'h00010a, 1'b0, 1'b0);
    send_seq(32, 24'h0, 1'b1, 1'b1);
    stop_stream();
    wait_cycles(3 * PT);
    chk("stall_fs_count", 32'(fs_seen), 32'd5);
    pulse_clr();
    chk("clr_uf3", 32'(underflow), 32'd0);

    // Start-of-frame injected at pixel 5.
    wait_cycles($urandom_range(0, 40));
    send_seq(4, 24'h000200, 1'b1, 1'b0);
    send_seq(32, 24'h0, 1'b1, 1'b1);
    stop_stream();
    wait_cycles(4 * PT);
    chk("early_sof_uf", 32'(underflow), 32'd1);
    chk("early_sof_fs_count", 32'(fs_seen), 32'd7);

    // Asynchronous reset mid-line while displaying.
    fork
      send_seq(32, 24'h0, 1'b1, 1'b1);
    join_none
    begin
      int n;
      n = 0;
      while (!(mode == M_RUN && pos == HT + 4) && n < 8 * PT) begin
        @(negedge clk);
        n++;
      end
      chk("reach_run_midline", 32'(mode == M_RUN && pos == HT + 4), 32'd1);
    end
    abort_send = 1'b1;
    #2 rst_n = 1'b0;
    pix_if.valid = 1'b0;
    pix_if.sof   = 1'b0;
    #1;
    chk("midrst_hsync", 32'(vga_hsync), 32'd1);
    chk("midrst_vsync", 32'(vga_vsync), 32'd1);
    chk("midrst_blank", 32'(vga_blank), 32'd1);
    chk("midrst_rgb", {8'h0, vga_red, vga_green, vga_blue}, 32'd0);
    chk("midrst_uf", 32'(underflow), 32'd0);
    chk("midrst_ready", 32'(pix_if.ready), 32'd1);
    wait_cycles(3);
    abort_send = 1'b0;
    release_reset();
    chk("post_rst_fs_count", 32'(fs_seen), 32'd8);

    // Clean frame after reset.
    wait_cycles(PT);
    send_seq(32, 24'h0, 1'b1, 1'b1);
    stop_stream();
    wait_cycles(3 * PT);
    chk("final_fs_count", 32'(fs_seen), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
